// File: rtl/div_16bit_seq.sv
// rtl/div_16bit_seq.sv - Iterative restoring divider, one quotient bit per cycle
// Optional two's complement operation is enabled by defining SIGNED_DIV_EN.
module div_16bit_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             Error
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, dvd_r, dsr_r;
    logic             accept, div_zero, last_iter;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_nxt, dvd_nxt;
    logic [WIDTH-1:0] dd_mag, ds_mag;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic             err_fin;

    assign accept    = start && (state != RUN);
    assign div_zero  = (divisor == '0);
    assign last_iter = (state == RUN) && (cnt == LAST);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // One restoring step: the sign of the W+1 bit difference decides restore vs keep.
    assign shifted = {rem_r, dvd_r[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_r};
    assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_nxt = {dvd_r[WIDTH-2:0], ~diff[WIDTH]};

`ifdef SIGNED_DIV_EN
    logic q_neg_r, r_neg_r, sat_r;

    assign dd_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    assign ds_mag = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;

    always_comb begin
        q_fin   = q_neg_r ? (~dvd_nxt + ONE) : dvd_nxt;
        r_fin   = r_neg_r ? (~rem_nxt + ONE) : rem_nxt;
        err_fin = 1'b0;
        // Most negative over -1 has no representable quotient.
        if (sat_r) begin
            q_fin   = {1'b0, {(WIDTH-1){1'b1}}};
            r_fin   = '0;
            err_fin = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            sat_r   <= 1'b0;
        end else if (accept && !div_zero) begin
            q_neg_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
            sat_r   <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
        end
    end
`else
    assign dd_mag = dividend;
    assign ds_mag = divisor;

    always_comb begin
        q_fin   = dvd_nxt;
        r_fin   = rem_nxt;
        err_fin = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = div_zero ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            RUN:     if (cnt == LAST) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_r     <= '0;
            dvd_r     <= '0;
            dsr_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
            Error     <= 1'b0;
        end else if (accept) begin
            if (div_zero) begin
                quotient  <= '1;
                remainder <= dividend;
                Error     <= 1'b1;
            end else begin
                dvd_r <= dd_mag;
                dsr_r <= ds_mag;
                rem_r <= '0;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            rem_r <= rem_nxt;
            dvd_r <= dvd_nxt;
            cnt   <= cnt + CW'(1);
            if (last_iter) begin
                quotient  <= q_fin;
                remainder <= r_fin;
                Error     <= err_fin;
            end
        end
    end

endmodule

// File: tb/tb_div_16bit_seq.sv
// tb/tb_div_16bit_seq.sv - Directed scoreboard bench for div_16bit_seq
module tb_div_16bit_seq;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend, divisor;
    logic        busy, done, Error;
    logic [15:0] quotient, remainder;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_16bit_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .Error    (Error)
    );

    function automatic exp_t ref_div(input logic [15:0] a, input logic [15:0] b);
        exp_t x;
        logic signed [15:0] sa, sb_;
        sa  = a;
        sb_ = b;
        if (b == 16'h0) begin
            x.q = 16'hFFFF; x.r = a; x.e = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            if (a == 16'h8000 && b == 16'hFFFF) begin
                x.q = 16'h7FFF; x.r = 16'h0; x.e = 1'b1;
            end else begin
                x.q = sa / sb_; x.r = sa % sb_; x.e = 1'b0;
            end
`else
            x.q = a / b; x.r = a % b; x.e = 1'b0;
            if (sa == sb_) x.e = 1'b0;
`endif
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge and record the expected result.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(ref_div(a, b));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Samples start just after the accepting edge; sample k is cycle N+k.
    task automatic wait_done(input int exp_lat, input int exp_busy);
        int   k;
        int   nbusy;
        logic found;
        exp_t x;
        found = 1'b0;
        nbusy = 0;
        for (k = 1; k <= 40; k++) begin
            if (busy) nbusy++;
            if (done) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("done_seen", {31'b0, found}, 32'd1);
        if (found) begin
            check("latency", k, exp_lat);
            check("busy_cycles", nbusy, exp_busy);
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                x = sb.pop_front();
                check("quotient", {16'b0, quotient}, {16'b0, x.q});
                check("remainder", {16'b0, remainder}, {16'b0, x.r});
                check("error", {31'b0, Error}, {31'b0, x.e});
            end
        end
    endtask

    task automatic done_drops();
        @(posedge clk);
        #1 check("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_q", {16'b0, quotient}, 32'd0);
        check("rst_r", {16'b0, remainder}, 32'd0);
        check("rst_err", {31'b0, Error}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        @(negedge clk) launch(16'd100, 16'd7);
        wait_done(17, 16);
        done_drops();

        @(negedge clk) launch(16'h04D2, 16'h0000);
        wait_done(1, 0);
        done_drops();

        @(negedge clk) launch(16'hFFFF, 16'h0001);
        wait_done(17, 16);
        @(negedge clk) launch(16'd5, 16'd9);
        wait_done(17, 16);
        @(negedge clk) launch(16'hBEEF, 16'h0123);
        wait_done(17, 16);

        // Second start during RUN must be ignored.
        @(negedge clk) launch(16'd100, 16'd7);
        repeat (4) @(posedge clk);
        #1;
        dividend = 16'h1234; divisor = 16'h0003; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(12, 11);
        done_drops();

        // Back-to-back: next start issued in the DONE cycle.
        @(negedge clk) launch(16'd1000, 16'd10);
        wait_done(17, 16);
        launch(16'd5, 16'd9);
        wait_done(17, 16);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk) launch(16'hABCD, 16'h0003);
        repeat (7) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_q", {16'b0, quotient}, 32'd0);
        check("mid_rst_r", {16'b0, remainder}, 32'd0);
        void'(sb.pop_back());
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(posedge clk);
            #1 if (done) ndone++;
        end
        check("no_done_after_rst", ndone, 32'd0);

`ifdef SIGNED_DIV_EN
        @(negedge clk) launch(16'hFFF9, 16'h0002);
        wait_done(17, 16);
        @(negedge clk) launch(16'h8000, 16'hFFFF);
        wait_done(17, 16);
        @(negedge clk) launch(16'h0007, 16'hFFFE);
        wait_done(17, 16);
        @(negedge clk) launch(16'h8000, 16'h0001);
        wait_done(17, 16);
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/div_16bit_seq.md
# div_16bit_seq

Iterative 16-bit restoring divider for the processor's compute datapath. It runs alongside the combinational add/sub and reduction units and is the multi-cycle arithmetic path the execute stage stalls on. It accepts operands on a start pulse and performs one quotient bit per cycle. It then presents quotient, remainder and an Error flag with a one-cycle done pulse. The Error flag follows the same saturation and overflow conventions as the adder.

## Interface
- WIDTH, 16, operand and result width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- dividend  input  WIDTH  numerator, captured when start is accepted
- divisor  input  WIDTH  denominator, captured when start is accepted
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when results become valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- Error  output  1  divide-by-zero or signed overflow; valid with done

## Operation
- States are IDLE, RUN and DONE. Reset places the block in IDLE.
- Reset values: busy=0, done=0, quotient=16'h0000, remainder=16'h0000, Error=0, iteration counter=0.
- IDLE or DONE, start=1, divisor≠0:
  - Capture the operand magnitudes.
  - Clear the partial remainder and set counter=0.
  - Move to RUN.
- IDLE or DONE, start=1, divisor=0:
  - Move straight to DONE with quotient=16'hFFFF, remainder=dividend, Error=1.
- DONE, start=0: move to IDLE. DONE always lasts exactly one cycle.
- RUN, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in a quotient bit of 1. Otherwise restore and shift in 0.
  - Increment the counter.
- When counter==WIDTH-1 completes, move to DONE and register the final quotient, remainder and Error=0.
- start while in RUN is ignored. No queueing takes place, and the captured operands are unaffected by changes on the inputs.
- quotient, remainder and Error hold their values from DONE until the next accepted start loads new results. Outputs are not cleared on entry to RUN.
- Arithmetic is unsigned by default. The partial remainder is WIDTH+1 bits wide, so no overflow is possible.

## Timing
- start is accepted at rising edge N.
- Normal divide:
  - busy=1 for cycles N+1 through N+WIDTH.
  - At N+WIDTH+1: done=1 and results are valid.
  - Latency is 17 cycles for WIDTH=16.
- Divide-by-zero: busy stays 0, done=1 at N+1, latency 1 cycle.
- A start asserted in the DONE cycle is accepted, so back-to-back operations run with no idle gap.
- If rst_n is asserted mid-RUN, the state returns to IDLE immediately and asynchronously. All outputs take their reset values, the partial result is discarded, and no done pulse is produced.

## Configuration
- Macro: SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at capture.
  - Quotient sign = dividend[15] ^ divisor[15]. Remainder sign follows the dividend.
  - Sign correction is applied when results are registered in DONE, so latency is unchanged.
  - 16'h8000 / 16'hFFFF saturates: quotient=16'h7FFF, remainder=0, Error=1.
  - Divide-by-zero behaves as in the unsigned case.
- Undefined: all operands and results are unsigned, and the saturation logic is not synthesized.

## Test plan
- Basic divide: dividend=100, divisor=7, start at edge N → busy for N+1..N+16; done at N+17 with quotient=14, remainder=2, Error=0.
- Divide by zero: dividend=16'h04D2, divisor=0 → done at N+1, busy never high; quotient=16'hFFFF, remainder=16'h04D2, Error=1.
- Unsigned boundary: 16'hFFFF / 1 → quotient=16'hFFFF, remainder=0. 5 / 9 → quotient=0, remainder=5.
- Handshake:
  - Assert start again with new operands at N+5 during RUN → ignored; results match the first operands.
  - Assert start in the DONE cycle → second done arrives exactly 17 cycles later.
- Reset mid-op: drop rst_n at N+8 → busy, done, quotient and remainder all read 0 immediately, and no done pulse follows after release.
- SIGNED_DIV_EN:
  - -7 / 2 → quotient=16'hFFFD, remainder=16'hFFFF.
  - 16'h8000 / 16'hFFFF → quotient=16'h7FFF, Error=1.
  - 7 / -2 → quotient=16'hFFFD, remainder=1.
